hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the hold/flush inputs of the PC, IF/ID, ID/EXE and EXE/MEM registers.
- Detects three conditions: load-use data hazards, taken-branch redirects resolved in EXE, and the structural hazard when the MEM stage occupies the shared SRAM.
- Sits beside the pipeline registers. It consumes decoder source-register info and the ID/EXE register outputs, and keeps saturating stall/flush performance counters.

Parameters:
MEM_CYCLES, 2, number of stall cycles a MEM-stage SRAM access occupies before it is acknowledged (legal range 1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
id_rs_addr  input  4  first source register of the instruction in ID
id_rs_used  input  1  instruction in ID reads id_rs_addr
id_rt_addr  input  4  second source register of the instruction in ID
id_rt_used  input  1  instruction in ID reads id_rt_addr
exe_mem_read  input  1  instruction in EXE is a load (ID/EXE mem_read output)
exe_reg_write  input  1  instruction in EXE writes a register
exe_reg_addr  input  4  destination register of the instruction in EXE
exe_branch_taken  input  1  branch in EXE resolved taken; PC loads target this cycle
mem_access_req  input  1  MEM stage needs SRAM (level, held stable while EXE/MEM is held)
perf_clr  input  1  synchronous clear of both performance counters
pc_hold  output  1  freeze PC
if_id_hold  output  1  freeze IF/ID
if_id_flush  output  1  bubble IF/ID
id_exe_hold  output  1  freeze ID/EXE
id_exe_flush  output  1  load NOP bubble into ID/EXE
exe_mem_hold  output  1  freeze EXE/MEM
mem_ack  output  1  one-cycle pulse: SRAM access complete, EXE/MEM advances this cycle
stall_count  output  CNT_W  cycles with any hold asserted (saturating)
flush_count  output  CNT_W  cycles with id_exe_flush asserted (saturating)

Behaviour:
- Reset (rst=0):
  - state=RUN, wait counter cnt=0, both perf counters 0.
  - All control outputs are forced 0 while rst is low, regardless of inputs.
- State register: RUN, MEM_WAIT. Control outputs are combinational from state, cnt and the current inputs (Mealy), so a hazard stalls in the same cycle it appears.
- Load-use hazard: lu = exe_mem_read & exe_reg_write & ((id_rs_used & id_rs_addr==exe_reg_addr) | (id_rt_used & id_rt_addr==exe_reg_addr)). There is no zero-register exclusion.
- RUN priority, highest first:
  1. mem_access_req:
     - pc_hold, if_id_hold, id_exe_hold and exe_mem_hold all =1; flushes 0.
     - Next state MEM_WAIT, cnt <= MEM_CYCLES-1.
  2. exe_branch_taken:
     - if_id_flush=1 and id_exe_flush=1; all holds 0 (PC takes the target).
     - Overrides lu, because the dependent instruction is on the wrong path.
  3. lu:
     - pc_hold=1, if_id_hold=1, id_exe_flush=1; id_exe_hold=0, exe_mem_hold=0.
     - Exactly one bubble; the load then moves to MEM and lu drops naturally.
  4. Otherwise all control outputs 0.
- MEM_WAIT:
  - cnt!=0: all four holds=1, flushes 0, mem_ack=0, cnt decrements. exe_branch_taken and lu are ignored; the frozen pipeline keeps them stable.
  - cnt==0 (ack cycle):
    - mem_ack=1, holds released, next state RUN.
    - Branch and lu rules from RUN priorities 2–3 apply in this same cycle.
    - mem_access_req is ignored in the ack cycle (it belongs to the completing access).
- Timing:
  - An access detected in RUN is stalled for exactly MEM_CYCLES cycles, then acked in the following cycle.
  - MEM_CYCLES=1 gives one stall cycle, then the ack.
  - Back-to-back accesses: a new req seen in RUN the cycle after the ack starts a new sequence.
- Perf counters, updated at the rising edge:
  - perf_clr=1 forces both to 0 and takes priority over incrementing.
  - stall_count +1 when any hold output was 1 that cycle.
  - flush_count +1 when id_exe_flush was 1.
  - Both saturate at all-ones (no wrap).
- Reset mid-MEM_WAIT: returns to RUN immediately, with cnt and counters cleared.

Test Plan:
- Reset with all inputs 1 → every control output 0 while rst=0. After release: state RUN, stall_count=0, flush_count=0.
- exe_mem_read=1, exe_reg_write=1, exe_reg_addr=3, id_rs_addr=3, id_rs_used=1 for one cycle → pc_hold=1, if_id_hold=1, id_exe_flush=1 that cycle; stall_count=1, flush_count=1. Same stimulus with id_rs_used=0 → no stall.
- MEM_CYCLES=2, mem_access_req held from cycle 0 → holds=1 in cycles 0–1, mem_ack=1 with holds=0 in cycle 2, back to RUN; stall_count=2.
- exe_branch_taken=1 together with a matching lu → if_id_flush=1, id_exe_flush=1, pc_hold=0.
- Branch taken asserted throughout MEM_WAIT (MEM_CYCLES=3) → no flush during cycles 0–2; the flush and mem_ack appear together in cycle 3.
- Preload by running 65535 stall cycles, then one more → stall_count stays 0xFFFF. perf_clr=1 → 0 next edge. rst low mid-MEM_WAIT → outputs 0 immediately, RUN after release.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and
// shared-SRAM structural stalls, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned MEM_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs_addr,
  input  logic             id_rs_used,
  input  logic [3:0]       id_rt_addr,
  input  logic             id_rt_used,
  input  logic             exe_mem_read,
  input  logic             exe_reg_write,
  input  logic [3:0]       exe_reg_addr,
  input  logic             exe_branch_taken,
  input  logic             mem_access_req,
  input  logic             perf_clr,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_exe_hold,
  output logic             id_exe_flush,
  output logic             exe_mem_hold,
  output logic             mem_ack,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;
  logic       any_hold;

  assign lu = exe_mem_read & exe_reg_write &
              ((id_rs_used & (id_rs_addr == exe_reg_addr)) |
               (id_rt_used & (id_rt_addr == exe_reg_addr)));

  // State and wait-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_access_req) begin
          state_d = MEM_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Mealy control outputs; the ack cycle falls through to branch/load-use rules
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_hold  = 1'b0;
    id_exe_flush = 1'b0;
    exe_mem_hold = 1'b0;
    mem_ack      = 1'b0;
    if ((state_q == RUN && mem_access_req) ||
        (state_q == MEM_WAIT && cnt_q != '0)) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_exe_hold  = 1'b1;
      exe_mem_hold = 1'b1;
    end else begin
      mem_ack = (state_q == MEM_WAIT);
      if (exe_branch_taken) begin
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
      end else if (lu) begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_exe_flush = 1'b1;
      end
    end
    if (!rst) begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_hold  = 1'b0;
      id_exe_flush = 1'b0;
      exe_mem_hold = 1'b0;
      mem_ack      = 1'b0;
    end
  end

  assign any_hold = pc_hold | if_id_hold | id_exe_hold | exe_mem_hold;

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (perf_clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (any_hold && stall_count != '1)     stall_count <= stall_count + 1'b1;
      if (id_exe_flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (MEM_CYCLES=2 and 3).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_rs_addr, id_rt_addr, exe_reg_addr;
  logic        id_rs_used, id_rt_used, exe_mem_read, exe_reg_write;
  logic        exe_branch_taken, mem_access_req, mem_access_req3, perf_clr;

  logic        pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_hold, mem_ack;
  logic [15:0] stall_count, flush_count;
  logic        pc_hold3, if_id_hold3, if_id_flush3, id_exe_hold3, id_exe_flush3, exe_mem_hold3, mem_ack3;
  logic [15:0] stall_count3, flush_count3;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // ctl bit order: pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_hold, mem_ack
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_HOLD   = 7'b1101010;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_BR     = 7'b0010100;
  localparam logic [6:0] C_ACK    = 7'b0000001;
  localparam logic [6:0] C_ACK_BR = 7'b0010101;
  localparam logic [6:0] C_ACK_LU = 7'b1100101;

  logic [6:0] ctl, ctl3;
  assign ctl  = {pc_hold, if_id_hold, if_id_flush, id_exe_hold, id_exe_flush, exe_mem_hold, mem_ack};
  assign ctl3 = {pc_hold3, if_id_hold3, if_id_flush3, id_exe_hold3, id_exe_flush3, exe_mem_hold3, mem_ack3};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .exe_mem_read(exe_mem_read), .exe_reg_write(exe_reg_write), .exe_reg_addr(exe_reg_addr),
    .exe_branch_taken(exe_branch_taken), .mem_access_req(mem_access_req), .perf_clr(perf_clr),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_exe_hold(id_exe_hold), .id_exe_flush(id_exe_flush), .exe_mem_hold(exe_mem_hold),
    .mem_ack(mem_ack), .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.MEM_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .exe_mem_read(exe_mem_read), .exe_reg_write(exe_reg_write), .exe_reg_addr(exe_reg_addr),
    .exe_branch_taken(exe_branch_taken), .mem_access_req(mem_access_req3), .perf_clr(perf_clr),
    .pc_hold(pc_hold3), .if_id_hold(if_id_hold3), .if_id_flush(if_id_flush3),
    .id_exe_hold(id_exe_hold3), .id_exe_flush(id_exe_flush3), .exe_mem_hold(exe_mem_hold3),
    .mem_ack(mem_ack3), .stall_count(stall_count3), .flush_count(flush_count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_addr = '0; id_rt_addr = '0; exe_reg_addr = '0;
    id_rs_used = 0; id_rt_used = 0; exe_mem_read = 0; exe_reg_write = 0;
    exe_branch_taken = 0; mem_access_req = 0; mem_access_req3 = 0; perf_clr = 0;
  endtask

  task automatic set_lu_rs(input logic used);
    exe_mem_read = 1; exe_reg_write = 1; exe_reg_addr = 4'd3;
    id_rs_addr = 4'd3; id_rs_used = used;
  endtask

  initial begin
    // Reset with every input driven high
    rst = 0;
    id_rs_addr = '1; id_rt_addr = '1; exe_reg_addr = '1;
    id_rs_used = 1; id_rt_used = 1; exe_mem_read = 1; exe_reg_write = 1;
    exe_branch_taken = 1; mem_access_req = 1; mem_access_req3 = 1; perf_clr = 1;
    #2;
    check("rst_ctl", 32'(ctl), 32'(C_NONE));
    step(); step();
    check("rst_ctl_late", 32'(ctl), 32'(C_NONE));
    check("rst_ctl3", 32'(ctl3), 32'(C_NONE));
    idle_inputs();
    rst = 1;
    #1;
    check("run_idle_ctl", 32'(ctl), 32'(C_NONE));
    step();
    check("rst_stall", 32'(stall_count), 32'd0);
    check("rst_flush", 32'(flush_count), 32'd0);

    // Load-use on rs
    set_lu_rs(1);
    #1 check("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    step();
    idle_inputs();
    check("lu_stall", 32'(stall_count), 32'd1);
    check("lu_flush", 32'(flush_count), 32'd1);
    // Same but rs not used
    set_lu_rs(0);
    #1 check("lu_unused_ctl", 32'(ctl), 32'(C_NONE));
    step();
    idle_inputs();
    check("lu_unused_stall", 32'(stall_count), 32'd1);
    // Load-use on rt, rs mismatching
    exe_mem_read = 1; exe_reg_write = 1; exe_reg_addr = 4'd0;
    id_rs_addr = 4'd5; id_rs_used = 1; id_rt_addr = 4'd0; id_rt_used = 1;
    #1 check("lu_rt_r0_ctl", 32'(ctl), 32'(C_LU));
    exe_reg_write = 0;
    #1 check("lu_no_write_ctl", 32'(ctl), 32'(C_NONE));
    idle_inputs();

    // Branch together with load-use
    step();
    perf_clr = 1;
    step();
    perf_clr = 0;
    set_lu_rs(1);
    exe_branch_taken = 1;
    #1 check("br_lu_ctl", 32'(ctl), 32'(C_BR));
    step();
    idle_inputs();
    check("br_stall", 32'(stall_count), 32'd0);
    check("br_flush", 32'(flush_count), 32'd1);

    // SRAM access, MEM_CYCLES=2, then back-to-back request
    perf_clr = 1;
    step();
    perf_clr = 0;
    mem_access_req = 1;
    #1 check("mem_c0", 32'(ctl), 32'(C_HOLD));
    step();
    check("mem_c1", 32'(ctl), 32'(C_HOLD));
    step();
    check("mem_c2_ack", 32'(ctl), 32'(C_ACK));
    step();
    check("mem_stall2", 32'(stall_count), 32'd2);
    check("mem_b2b_c0", 32'(ctl), 32'(C_HOLD));
    step();
    check("mem_b2b_c1", 32'(ctl), 32'(C_HOLD));
    step();
    // Load-use appearing in the ack cycle
    set_lu_rs(1);
    #1 check("mem_ack_lu", 32'(ctl), 32'(C_ACK_LU));
    step();
    idle_inputs();
    #1 check("mem_after", 32'(ctl), 32'(C_NONE));
    check("mem_stall5", 32'(stall_count), 32'd5);
    check("mem_flush1", 32'(flush_count), 32'd1);

    // Branch held through MEM_WAIT, MEM_CYCLES=3
    step();
    mem_access_req3 = 1;
    exe_branch_taken = 1;
    #1 check("m3_c0", 32'(ctl3), 32'(C_HOLD));
    step();
    check("m3_c1", 32'(ctl3), 32'(C_HOLD));
    step();
    check("m3_c2", 32'(ctl3), 32'(C_HOLD));
    step();
    check("m3_c3_ack_br", 32'(ctl3), 32'(C_ACK_BR));
    step();
    idle_inputs();
    #1 check("m3_after", 32'(ctl3), 32'(C_NONE));

    // Saturation via continuous load-use stalls
    perf_clr = 1;
    step();
    perf_clr = 0;
    set_lu_rs(1);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_stall_ffff", 32'(stall_count), 32'h0000_FFFF);
    check("sat_flush_ffff", 32'(flush_count), 32'h0000_FFFF);
    step();
    check("sat_stall_hold", 32'(stall_count), 32'h0000_FFFF);
    check("sat_flush_hold", 32'(flush_count), 32'h0000_FFFF);
    perf_clr = 1;
    step();
    check("clr_stall", 32'(stall_count), 32'd0);
    check("clr_flush", 32'(flush_count), 32'd0);
    idle_inputs();

    // Reset in the middle of MEM_WAIT
    mem_access_req = 1;
    step();
    check("rstmw_hold", 32'(ctl), 32'(C_HOLD));
    rst = 0;
    #1;
    check("rstmw_ctl", 32'(ctl), 32'(C_NONE));
    check("rstmw_stall", 32'(stall_count), 32'd0);
    step();
    mem_access_req = 0;
    rst = 1;
    set_lu_rs(1);
    #1 check("rstmw_run_lu", 32'(ctl), 32'(C_LU));
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
